// File: rtl/sdram_arbit_rr_if.sv
// Engine-side and pin-side bus of the round-robin SDRAM arbiter.
// master: init/aref/channel engines and pads; slave: the arbiter.
interface sdram_arbit_rr_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2,
    parameter int DQ_W   = 16
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                    flag_init_end;
    logic [3:0]              init_cmd;
    logic [ADDR_W-1:0]       init_addr;

    logic                    ref_req;
    logic                    ref_en;
    logic                    flag_ref_end;
    logic [3:0]              ref_cmd;
    logic [ADDR_W-1:0]       ref_addr;

    logic [NCH-1:0]          ch_req;
    logic [NCH-1:0]          ch_en;
    logic [NCH-1:0]          ch_end;
    logic [4*NCH-1:0]        ch_cmd;
    logic [ADDR_W*NCH-1:0]   ch_addr;
    logic [BANK_W*NCH-1:0]   ch_bank;
    logic [DQ_W*NCH-1:0]     ch_wdata;

    logic [3:0]              sdram_cmd;
    logic [ADDR_W-1:0]       sdram_addr;
    logic [BANK_W-1:0]       sdram_bank;
    logic                    dq_oe;
    logic [DQ_W-1:0]         dq_out;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    busy;
    logic                    arb_err;

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output ref_req, flag_ref_end, ref_cmd, ref_addr,
        output ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata,
        input  ref_en, ch_en,
        input  sdram_cmd, sdram_addr, sdram_bank, dq_oe, dq_out,
        input  gnt_idx, busy, arb_err
    );

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  ref_req, flag_ref_end, ref_cmd, ref_addr,
        input  ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata,
        output ref_en, ch_en,
        output sdram_cmd, sdram_addr, sdram_bank, dq_oe, dq_out,
        output gnt_idx, busy, arb_err
    );
endinterface

// File: rtl/sdram_arbit_rr.sv
// SDRAM bus arbiter: refresh first, then round-robin over NCH channel engines.
// Optional watchdog abort of stuck AREF/GRANT when SDRAM_ARB_WDOG_EN is defined.
module sdram_arbit_rr #(
    parameter int             NCH     = 2,
    parameter int             ADDR_W  = 13,
    parameter int             BANK_W  = 2,
    parameter int             DQ_W    = 16,
    parameter logic [NCH-1:0] WR_MASK = NCH'(2'b01),
    parameter int             TIMEOUT = 1023
) (
    input logic             sclk,
    input logic             s_rst_n,
    sdram_arbit_rr_if.slave bus
);
    localparam int         IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    if (NCH < 2 || NCH > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("sdram_arbit_rr: NCH must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ARBIT = 4'b0010,
        AREF  = 4'b0100,
        GRANT = 4'b1000
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [NCH-1:0]   ch_en;
    logic             ref_en;
    logic             arb_err;
    logic [IDX_W-1:0] winner;
    logic             win_found;
    logic             wd_expire;
    logic             busy;

    logic [3:0]        cmd_a   [NCH];
    logic [ADDR_W-1:0] addr_a  [NCH];
    logic [BANK_W-1:0] bank_a  [NCH];
    logic [DQ_W-1:0]   wdata_a [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign cmd_a[i]   = bus.ch_cmd[i*4 +: 4];
        assign addr_a[i]  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        assign bank_a[i]  = bus.ch_bank[i*BANK_W +: BANK_W];
        assign wdata_a[i] = bus.ch_wdata[i*DQ_W +: DQ_W];
    end

    // First requester at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        int               scan;
        logic [IDX_W-1:0] cand;
        // NOTE: every variable gets a default first so no path infers a latch.
        winner    = rr_ptr;
        win_found = 1'b0;
        scan      = 0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NCH) scan = scan - NCH;
            cand = IDX_W'(scan);
            if (!win_found && bus.ch_req[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            ref_en  <= 1'b0;
            ch_en   <= '0;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            arb_err <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; pulse outputs default low each cycle.
            ref_en  <= 1'b0;
            ch_en   <= '0;
            arb_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.flag_init_end) state <= ARBIT;
                end
                ARBIT: begin
                    if (bus.ref_req) begin
                        state  <= AREF;
                        ref_en <= 1'b1;
                    end else if (win_found) begin
                        state   <= GRANT;
                        gnt_idx <= winner;
                        ch_en   <= NCH'(1) << winner;
                        rr_ptr  <= (winner == IDX_W'(NCH - 1)) ? '0 : winner + 1'b1;
                    end
                end
                AREF: begin
                    if (bus.flag_ref_end) begin
                        state <= ARBIT;
                    end else if (wd_expire) begin
                        state   <= ARBIT;
                        arb_err <= 1'b1;
                    end
                end
                GRANT: begin
                    if (bus.ch_end[gnt_idx]) begin
                        state <= ARBIT;
                    end else if (wd_expire) begin
                        state   <= ARBIT;
                        arb_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == AREF) || (state == GRANT);

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Zero while arbitrating, so each AREF/GRANT starts counting from 0.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)  wd_cnt <= '0;
        else if (busy) wd_cnt <= wd_cnt + 1'b1;
        else           wd_cnt <= '0;
    end

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = '0;
        bus.sdram_bank = '0;
        bus.dq_oe      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            AREF: begin
                bus.sdram_cmd  = bus.ref_cmd;
                bus.sdram_addr = bus.ref_addr;
            end
            GRANT: begin
                bus.sdram_cmd  = cmd_a[gnt_idx];
                bus.sdram_addr = addr_a[gnt_idx];
                bus.sdram_bank = bank_a[gnt_idx];
                bus.dq_oe      = WR_MASK[gnt_idx];
            end
            default: ;
        endcase
    end

    assign bus.dq_out  = wdata_a[gnt_idx];
    assign bus.ref_en  = ref_en;
    assign bus.ch_en   = ch_en;
    assign bus.gnt_idx = gnt_idx;
    assign bus.busy    = busy;
    assign bus.arb_err = arb_err;
endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Scoreboard bench for sdram_arbit_rr: grant predictions are queued by the stimulus
// and popped by an independent monitor whenever ref_en/ch_en pulses.
module tb_sdram_arbit_rr;
    localparam int         NCH     = 2;
    localparam int         ADDR_W  = 13;
    localparam int         BANK_W  = 2;
    localparam int         DQ_W    = 16;
    localparam logic [1:0] WR_MASK = 2'b01;
    localparam int         TMO     = 15;
    localparam int         CMD_W   = 4 * NCH;
    localparam int         CADDR_W = ADDR_W * NCH;
    localparam int         CBANK_W = BANK_W * NCH;
    localparam int         CDQ_W   = DQ_W * NCH;

    typedef enum int {M_IDLE, M_ARBIT, M_AREF, M_GRANT} mode_t;
    typedef struct {
        bit is_ref;
        int idx;
        int gidx;
    } exp_t;

    logic sclk = 1'b0;
    logic s_rst_n;
    always #5 sclk = ~sclk;

    sdram_arbit_rr_if #(.NCH(NCH), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W)) bus ();

    sdram_arbit_rr #(
        .NCH(NCH), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W),
        .WR_MASK(WR_MASK), .TIMEOUT(TMO)
    ) dut (
        .sclk(sclk),
        .s_rst_n(s_rst_n),
        .bus(bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   ptr  = 0;   // reference round-robin pointer
    int   last = 0;   // reference last granted channel

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] r);
        for (int k = 0; k < NCH; k++) begin
            if (r[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic randomize_data();
        bus.init_cmd  = 4'($urandom);
        bus.init_addr = ADDR_W'($urandom);
        bus.ref_cmd   = 4'($urandom);
        bus.ref_addr  = ADDR_W'($urandom);
        bus.ch_cmd    = CMD_W'($urandom);
        bus.ch_addr   = CADDR_W'($urandom);
        bus.ch_bank   = CBANK_W'($urandom);
        bus.ch_wdata  = CDQ_W'($urandom);
    endtask

    task automatic check_bus(input mode_t m, input int w);
        logic [3:0]        ecmd;
        logic [ADDR_W-1:0] eaddr;
        logic [BANK_W-1:0] ebank;
        logic              eoe;
        ecmd  = 4'b0111;
        eaddr = '0;
        ebank = '0;
        eoe   = 1'b0;
        case (m)
            M_IDLE: begin ecmd = bus.init_cmd; eaddr = bus.init_addr; end
            M_AREF: begin ecmd = bus.ref_cmd;  eaddr = bus.ref_addr;  end
            M_GRANT: begin
                ecmd  = 4'(bus.ch_cmd >> (4 * w));
                eaddr = ADDR_W'(bus.ch_addr >> (ADDR_W * w));
                ebank = BANK_W'(bus.ch_bank >> (BANK_W * w));
                eoe   = WR_MASK[w];
            end
            default: ;
        endcase
        check("sdram_cmd", bus.sdram_cmd, ecmd);
        check("sdram_addr", bus.sdram_addr, eaddr);
        check("sdram_bank", bus.sdram_bank, ebank);
        check("dq_oe", bus.dq_oe, eoe);
        check("busy", bus.busy, (m == M_AREF || m == M_GRANT));
        if (m == M_GRANT) check("dq_out", bus.dq_out, DQ_W'(bus.ch_wdata >> (DQ_W * w)));
    endtask

    // Entered at a negedge while the DUT is arbitrating; leaves at the next such point.
    task automatic do_round(input int hold, input bit rnd, input bit keep);
        exp_t  e;
        mode_t m;
        int    w;
        if (!bus.ref_req && bus.ch_req == '0) begin
            @(negedge sclk);
            randomize_data();
            if (rnd) bus.ch_req = NCH'($urandom);
            #1 check_bus(M_ARBIT, 0);
            return;
        end
        if (bus.ref_req) begin
            m = M_AREF;
            w = last;
            e = '{1'b1, 0, last};
        end else begin
            m    = M_GRANT;
            w    = pick(bus.ch_req);
            e    = '{1'b0, w, w};
            ptr  = (w + 1) % NCH;
            last = w;
        end
        exp_q.push_back(e);
        @(negedge sclk);
        if (m == M_AREF) bus.ref_req = 1'b0;
        else if (!keep)  bus.ch_req[w] = 1'b0;
        for (int c = 0; c <= hold; c++) begin
            if (c > 0) @(negedge sclk);
            randomize_data();
            bus.ch_end       = '0;
            bus.flag_ref_end = 1'b0;
            if (rnd) begin
                bus.ch_end = NCH'($urandom);
                if (m == M_GRANT) bus.ch_end[w] = 1'b0;
                if ($urandom_range(0, 3) == 0) bus.ref_req = 1'b1;
                bus.ch_req = bus.ch_req | (NCH'($urandom) & NCH'($urandom));
            end
            if (c == hold) begin
                if (m == M_AREF) bus.flag_ref_end = 1'b1;
                else             bus.ch_end[w] = 1'b1;
            end
            #1;
            if (c == 0) check("grant_latency", exp_q.size(), 0);
            check_bus(m, w);
            check("arb_err_quiet", bus.arb_err, 0);
        end
        @(negedge sclk);
        bus.ch_end       = '0;
        bus.flag_ref_end = 1'b0;
        randomize_data();
        #1 check_bus(M_ARBIT, 0);
    endtask

    // Monitor: every grant pulse must match the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge sclk);
            if (s_rst_n === 1'b1 && (bus.ref_en !== 1'b0 || bus.ch_en !== '0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {bus.ref_en, bus.ch_en}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ref_en", bus.ref_en, e.is_ref);
                    check("ch_en", bus.ch_en, e.is_ref ? 0 : (1 << e.idx));
                    check("gnt_idx", bus.gnt_idx, e.gidx);
                end
            end
        end
    end

    initial begin
        int k;
        s_rst_n           = 1'b0;
        bus.flag_init_end = 1'b0;
        bus.ref_req       = 1'b1;
        bus.ch_req        = '1;
        bus.ch_end        = '0;
        bus.flag_ref_end  = 1'b0;
        randomize_data();
        repeat (3) @(negedge sclk);
        #1;
        check("rst_ref_en", bus.ref_en, 0);
        check("rst_ch_en", bus.ch_en, 0);
        check("rst_gnt_idx", bus.gnt_idx, 0);
        check("rst_arb_err", bus.arb_err, 0);
        check_bus(M_IDLE, 0);
        s_rst_n = 1'b1;

        // Requests are held high throughout IDLE and must be ignored.
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge sclk);
            randomize_data();
            #1 check_bus(M_IDLE, 0);
        end
        @(negedge sclk);
        bus.flag_init_end = 1'b1;
        #1 check_bus(M_IDLE, 0);
        @(negedge sclk);
        #1 check_bus(M_ARBIT, 0);

        // Refresh wins first, then both channels held: ch0, ch1, ch0, ch1.
        do_round(3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_round(3, 1'b0, 1'b1);

        // Refresh and ch1 together: refresh, then ch1.
        bus.ch_req  = 2'b10;
        bus.ref_req = 1'b1;
        do_round(2, 1'b0, 1'b0);
        do_round(2, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) do_round($urandom_range(0, 4), 1'b1, 1'b0);

        // Drain leftovers without new traffic.
        for (int i = 0; i < 6; i++) do_round(1, 1'b0, 1'b0);

        // Reset mid-grant after ch0 won (pointer at 1): must restart from ch0.
        bus.ref_req = 1'b0;
        bus.ch_req  = 2'b01;
        exp_q.push_back('{1'b0, 0, 0});
        ptr  = 1;
        last = 0;
        @(negedge sclk);
        bus.ch_req = '0;
        #1 check("grant_latency", exp_q.size(), 0);
        check_bus(M_GRANT, 0);
        @(negedge sclk);
        s_rst_n = 1'b0;
        #1 check_bus(M_IDLE, 0);
        check("rst_mid_gnt_idx", bus.gnt_idx, 0);
        ptr        = 0;
        last       = 0;
        bus.ch_req = 2'b11;
        @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);
        #1 check_bus(M_ARBIT, 0);
        do_round(2, 1'b0, 1'b0);
        do_round(2, 1'b0, 1'b0);

`ifdef SDRAM_ARB_WDOG_EN
        // ch0 never ends: watchdog aborts after TMO cycles, ch1 wins next.
        bus.ch_req = 2'b01;
        exp_q.push_back('{1'b0, 0, 0});
        ptr  = 1;
        last = 0;
        @(negedge sclk);
        bus.ch_req = 2'b10;
        #1 check("grant_latency", exp_q.size(), 0);
        k = 0;
        while (k < 40 && bus.arb_err !== 1'b1) begin
            @(negedge sclk);
            #1 k++;
        end
        check("wdog_cycles", k, TMO);
        check_bus(M_ARBIT, 0);
        do_round(2, 1'b0, 1'b0);
`else
        k = 0;
`endif

        bus.ch_req  = '0;
        bus.ref_req = 1'b0;
        repeat (3) @(negedge sclk);
        #1 check("queue_drained", exp_q.size(), 0);
        check("final_busy", bus.busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
